// File: rtl/led_16_pkg.sv
// Shared types and constants for the 16-LED pattern controller.
//   mode_e : pattern selector (rotate / bounce)
//   dir_e  : travel direction of the bouncing light
//   LED_INIT / LED_MSB : end positions of the one-hot LED word
//   is_one_hot() : true when exactly one bit of a 16-bit word is set
package led_16_pkg;

    typedef enum logic {
        MODE_ROTATE = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    localparam logic [15:0] LED_INIT = 16'h0001;
    localparam logic [15:0] LED_MSB  = 16'h8000;

    function automatic logic is_one_hot(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate divider for the LED controller.
//   clk, rst   : system clock, asynchronous active-low reset
//   speed_i    : synchronized speed switch (1 = DIV_FAST, 0 = DIV_SLOW)
//   clear_i    : forces the counter to 0 and suppresses the tick this cycle
//   tick_o     : one-cycle pulse every DIV clocks
module led_tick_gen #(
    parameter int unsigned DIV_FAST = 4,
    parameter int unsigned DIV_SLOW = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic speed_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             speed_q;
    logic [CNT_W-1:0] last;
    logic             speed_chg;

    assign last      = speed_i ? FAST_LAST : SLOW_LAST;
    // Restart on a rate change so the count can never sit above the new terminal value.
    assign speed_chg = (speed_i != speed_q);

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_o = 1'b0;
        if (clear_i || speed_chg) begin
            cnt_d = '0;
        end else if (cnt_q == last) begin
            cnt_d  = '0;
            tick_o = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            speed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            speed_q <= speed_i;
        end
    end

endmodule

// File: rtl/led_16_controller.sv
// Sixteen-LED pattern generator: rotating or bouncing one-hot light.
//   clk, rst    : system clock, asynchronous active-low reset
//   speed       : async switch, 1 = fast step rate, 0 = slow
//   state_ctrl  : async switch, 0 = rotate, 1 = bounce
//   led[15:0]   : registered active-high LED drive
//   clk_show    : registered, toggles on every step
module led_16_controller
    import led_16_pkg::*;
#(
    parameter int unsigned DIV_FAST = 4,
    parameter int unsigned DIV_SLOW = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        speed,
    input  logic        state_ctrl,
    output logic [15:0] led,
    output logic        clk_show
);

    logic        speed_s1_q, speed_s2_q;
    logic        state_s1_q, state_s2_q;
    logic [15:0] led_q, led_d;
    logic        show_q, show_d;
    mode_e       mode_q, mode_d;
    dir_e        dir_q, dir_d;
    logic        mode_chg;
    logic        tick;

    assign mode_chg = (mode_q != mode_e'(state_s2_q));

    led_tick_gen #(
        .DIV_FAST (DIV_FAST),
        .DIV_SLOW (DIV_SLOW),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .speed_i (speed_s2_q),
        .clear_i (mode_chg),
        .tick_o  (tick)
    );

    always_comb begin
        led_d  = led_q;
        show_d = show_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        if (mode_chg) begin
            // Pattern restart takes priority over any step this cycle.
            mode_d = mode_e'(state_s2_q);
            led_d  = LED_INIT;
            dir_d  = DIR_UP;
        end else if (tick) begin
            show_d = ~show_q;
            if (!is_one_hot(led_q)) begin
                led_d = LED_INIT;
                dir_d = DIR_UP;
            end else if (mode_q == MODE_ROTATE) begin
                led_d = {led_q[14:0], led_q[15]};
            end else begin
                unique case (dir_q)
                    DIR_UP: begin
                        if (led_q == LED_MSB) begin
                            dir_d = DIR_DOWN;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end
                    DIR_DOWN: begin
                        if (led_q == LED_INIT) begin
                            dir_d = DIR_UP;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                    default: led_d = LED_INIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_s1_q <= 1'b0;
            speed_s2_q <= 1'b0;
            state_s1_q <= 1'b0;
            state_s2_q <= 1'b0;
            led_q      <= LED_INIT;
            show_q     <= 1'b0;
            mode_q     <= MODE_ROTATE;
            dir_q      <= DIR_UP;
        end else begin
            speed_s1_q <= speed;
            speed_s2_q <= speed_s1_q;
            state_s1_q <= state_ctrl;
            state_s2_q <= state_s1_q;
            led_q      <= led_d;
            show_q     <= show_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
        end
    end

    assign led      = led_q;
    assign clk_show = show_q;

endmodule

// File: tb/tb_led_16_controller.sv
module tb_led_16_controller;

    logic        clk;
    logic        rst;
    logic        speed;
    logic        state_ctrl;
    logic [15:0] led;
    logic        clk_show;

    int checks = 0;
    int errors = 0;

    led_16_controller #(
        .DIV_FAST (4),
        .DIV_SLOW (16),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .speed      (speed),
        .state_ctrl (state_ctrl),
        .led        (led),
        .clk_show   (clk_show)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, ending on a falling edge.
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        speed      = 1'b0;
        state_ctrl = 1'b0;
        edges(3);
        check("reset_led", led, 16'h0001);
        check("reset_show", {15'd0, clk_show}, 16'd0);

        // Slow rate out of reset: first step on the 16th edge.
        rst = 1'b1;
        edges(15);
        check("slow_pre_step_led", led, 16'h0001);
        check("slow_pre_step_show", {15'd0, clk_show}, 16'd0);
        edges(1);
        check("slow_first_step_led", led, 16'h0002);
        check("slow_first_step_show", {15'd0, clk_show}, 16'd1);

        // Go fast: speed change clears the divider on the 3rd edge, then a step every 4.
        speed = 1'b1;
        edges(3);
        check("fast_switch_led", led, 16'h0002);
        edges(3);
        check("fast_pre_step_led", led, 16'h0002);
        edges(1);
        check("fast_step2_led", led, 16'h0004);
        check("fast_step2_show", {15'd0, clk_show}, 16'd0);
        edges(4);
        check("fast_step3_led", led, 16'h0008);
        check("fast_step3_show", {15'd0, clk_show}, 16'd1);

        // Rotate wrap.
        edges(4 * 12);
        check("rotate_step15_led", led, 16'h8000);
        check("rotate_step15_show", {15'd0, clk_show}, 16'd1);
        edges(4);
        check("rotate_wrap_led", led, 16'h0001);
        check("rotate_wrap_show", {15'd0, clk_show}, 16'd0);
        edges(4);
        check("rotate_step17_led", led, 16'h0002);

        // Asynchronous reset mid-pattern.
        rst = 1'b0;
        #1;
        check("midreset_led", led, 16'h0001);
        check("midreset_show", {15'd0, clk_show}, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        // Synchronizers restart at 0, so speed=1 arrives as a change: clear at edge 3, step at 7.
        edges(6);
        check("rerun_pre_step_led", led, 16'h0001);
        edges(1);
        check("rerun_step1_led", led, 16'h0002);
        check("rerun_step1_show", {15'd0, clk_show}, 16'd1);

        // Bounce.
        state_ctrl = 1'b1;
        edges(2);
        check("bounce_pre_switch_led", led, 16'h0002);
        edges(1);
        check("bounce_switch_led", led, 16'h0001);
        check("bounce_switch_show", {15'd0, clk_show}, 16'd1);
        edges(4);
        check("bounce_step1_led", led, 16'h0002);
        check("bounce_step1_show", {15'd0, clk_show}, 16'd0);
        edges(4 * 14);
        check("bounce_step15_led", led, 16'h8000);
        edges(4);
        check("bounce_step16_led", led, 16'h4000);
        check("bounce_step16_show", {15'd0, clk_show}, 16'd1);
        edges(4 * 14);
        check("bounce_step30_led", led, 16'h0001);
        edges(4);
        check("bounce_step31_led", led, 16'h0002);
        check("bounce_step31_show", {15'd0, clk_show}, 16'd0);

        // Drop to slow rate mid-pattern.
        speed = 1'b0;
        edges(3);
        check("slow_switch_led", led, 16'h0002);
        check("slow_switch_show", {15'd0, clk_show}, 16'd0);
        edges(15);
        check("slow_pre_step_b_led", led, 16'h0002);
        edges(1);
        check("slow_step_b_led", led, 16'h0004);
        check("slow_step_b_show", {15'd0, clk_show}, 16'd1);
        edges(15);
        check("slow_pre_step_c_show", {15'd0, clk_show}, 16'd1);
        edges(1);
        check("slow_step_c_led", led, 16'h0008);
        check("slow_step_c_show", {15'd0, clk_show}, 16'd0);

        // Mode change landing on a tick edge (16 edges after the last step).
        edges(13);
        state_ctrl = 1'b0;
        edges(2);
        check("collide_pre_led", led, 16'h0008);
        edges(1);
        check("collide_led", led, 16'h0001);
        check("collide_show", {15'd0, clk_show}, 16'd0);
        edges(16);
        check("collide_next_led", led, 16'h0002);
        check("collide_next_show", {15'd0, clk_show}, 16'd1);

        // Corrupted LED word is repaired on the next step.
        force dut.led_q = 16'h0003;
        #1;
        release dut.led_q;
        #1;
        check("glitch_held_led", led, 16'h0003);
        edges(15);
        check("glitch_pre_step_led", led, 16'h0003);
        edges(1);
        check("glitch_fix_led", led, 16'h0001);
        check("glitch_fix_show", {15'd0, clk_show}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
